seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package div_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, select.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quot_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // The extra top bit of the trial difference is the borrow.
  always_comb begin
    shifted    = {rem_i, bit_i};
    trial      = {1'b0, shifted} - {2'b00, divisor_i};
    quot_bit_o = ~trial[WIDTH+1];
    rem_o      = quot_bit_o ? WIDTH'(trial) : WIDTH'(shifted);
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider with valid/ready handshakes.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e       state_q;
  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q, dvnd_q;
  logic [CntW-1:0]  cnt_q;
  logic             fin_q;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg_q, r_neg_q;

  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign q_fix = q_neg_q ? -quot_q : quot_q;
  assign r_fix = r_neg_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (state_q == StIdle && in_valid) begin
      q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_q <= dividend[WIDTH-1];
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = quot_q;
  assign r_fix = rem_q;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (quot_q[WIDTH-1]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quot_bit_o(step_bit)
  );

  // quot_q starts as the dividend and fills with quotient bits as they shift out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      dvnd_q      <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q  <= StCalc;
            in_ready <= 1'b0;
            rem_q    <= '0;
            quot_q   <= a_mag;
            dvsr_q   <= b_mag;
            dvnd_q   <= dividend;
            cnt_q    <= CntW'(WIDTH - 1);
            fin_q    <= 1'b0;
          end
        end
        StCalc: begin
          if (dvsr_q == '0) begin
            state_q     <= StDone;
            out_valid   <= 1'b1;
            quotient    <= '1;
            remainder   <= dvnd_q;
            div_by_zero <= 1'b1;
          end else if (fin_q) begin
            state_q     <= StDone;
            out_valid   <= 1'b1;
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end else begin
            rem_q  <= step_rem;
            quot_q <= {quot_q[WIDTH-2:0], step_bit};
            cnt_q  <= cnt_q - CntW'(1);
            fin_q  <= (cnt_q == '0);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8) against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    int sa, sb;
    z = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair, time the result, hold it for `stall` cycles, then hand it off.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    model(a, b, eq, er, ez);
    check("ready_before_accept", in_ready, 1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    lat = 0;
    do begin
      in_valid = 1'(($urandom % 2));
      dividend = W'($urandom);
      divisor  = W'($urandom);
      step();
      lat++;
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    check("latency", lat, (b == '0) ? 1 : W + 1);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    for (int i = 0; i < stall; i++) begin
      step();
      check("hold_valid", out_valid, 1);
      check("hold_quotient", quotient, eq);
      check("hold_remainder", remainder, er);
      check("hold_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    check("ready_low_at_handshake", in_ready, 0);
    step();
    out_ready = 1'b0;
    check("valid_after_handshake", out_valid, 0);
    check("ready_after_handshake", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // Reset with in_valid high must not accept anything.
    rst      = 1'b1;
    in_valid = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd3;
    step();
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();

    run_div(8'd100, 8'd7, 0);
    run_div(8'd255, 8'd1, 1);
    run_div(8'd200, 8'd250, 0);
    run_div(8'd37, 8'd0, 2);
    run_div(8'd100, 8'd7, 5);

    // Reset in the middle of a calculation discards it.
    dividend = 8'd77;
    divisor  = 8'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("calc_no_valid", out_valid, 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    step();
    check("midreset_stays_idle", out_valid, 0);
    run_div(8'd50, 8'd5, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div(8'hF9, 8'd2, 0);
    run_div(8'h80, 8'hFF, 0);
`endif

    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = (n % 6 == 0) ? '0 : W'($urandom);
      if (n == 3) ra = 8'hFF;
      if (n == 4) rb = 8'h80;
      run_div(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
